// File: rtl/cache_control.sv
// Control FSM for the 2-way set-associative L1 cache datapath.
// The package carries the datapath mux-select encodings and the FSM state
// type, so the datapath and any bench can share them.
package pkg_cache;

  typedef enum logic { W_HIT   = 1'b0, W_LRU   = 1'b1 } waymux_t;
  typedef enum logic { D_CPU   = 1'b0, D_LLC   = 1'b1 } datamux_t;
  typedef enum logic { M_CACHE = 1'b0, M_LLC   = 1'b1 } merdmux_t;
  typedef enum logic { P_CPU   = 1'b0, P_CACHE = 1'b1 } pmadmux_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

endpackage

// Handshakes: mem_read/mem_write are held by the CPU until the one-cycle
// mem_resp pulse; pmem_read/pmem_write are held by this block until the
// one-cycle pmem_resp pulse from the LLC. A pmem_resp seen outside
// WRITEBACK/ALLOCATE is ignored.
module cache_control
  import pkg_cache::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  input  logic                 hit,
  input  logic                 lru_dirty,
  output waymux_t              waymux_sel,
  output datamux_t             datamux_sel,
  output merdmux_t             merdmux_sel,
  output pmadmux_t             pmadmux_sel,
  output logic                 load_data,
  output logic                 load_tag,
  output logic                 set_valid,
  output logic                 set_dirty,
  output logic                 clr_dirty,
  output logic                 load_lru,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output state_t               state_dbg
);

  state_t state_q, state_d;

  // Set when a write miss has just been filled; the follow-up CHECK then
  // merges the CPU data without being counted as a second hit or miss.
  logic refill_q;
  logic refill_set, refill_clr;
  logic hit_inc, miss_inc;

  assign state_dbg = state_q;

  // State, refill flag and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      refill_q   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state_q <= state_d;
      if (refill_set) begin
        refill_q <= 1'b1;
      end else if (refill_clr) begin
        refill_q <= 1'b0;
      end
      if (hit_inc) begin
        hit_count <= hit_count + CNT_WIDTH'(1);
      end
      if (miss_inc) begin
        miss_count <= miss_count + CNT_WIDTH'(1);
      end
    end
  end

  // Next state and all datapath controls. Everything is held at its idle
  // default while rst is high so a pending pmem request drops at once.
  always_comb begin
    state_d     = state_q;
    mem_resp    = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    load_data   = 1'b0;
    load_tag    = 1'b0;
    set_valid   = 1'b0;
    set_dirty   = 1'b0;
    clr_dirty   = 1'b0;
    load_lru    = 1'b0;
    waymux_sel  = W_HIT;
    datamux_sel = D_CPU;
    merdmux_sel = M_CACHE;
    pmadmux_sel = P_CPU;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    refill_set  = 1'b0;
    refill_clr  = 1'b0;

    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (mem_read || mem_write) begin
            state_d = CHECK;
          end
        end

        CHECK: begin
          if (hit) begin
            mem_resp   = 1'b1;
            load_lru   = 1'b1;
            refill_clr = 1'b1;
            hit_inc    = !refill_q;
            // A simultaneous read+write is handled as a write.
            if (mem_write) begin
              load_data = 1'b1;
              set_dirty = 1'b1;
            end
            state_d = IDLE;
          end else begin
            miss_inc = !refill_q;
            state_d  = lru_dirty ? WRITEBACK : ALLOCATE;
          end
        end

        WRITEBACK: begin
          pmem_write  = 1'b1;
          waymux_sel  = W_LRU;
          pmadmux_sel = P_CACHE;
          if (pmem_resp) begin
            clr_dirty = 1'b1;
            state_d   = ALLOCATE;
          end
        end

        ALLOCATE: begin
          pmem_read   = 1'b1;
          waymux_sel  = W_LRU;
          pmadmux_sel = P_CPU;
          if (pmem_resp) begin
            load_data   = 1'b1;
            load_tag    = 1'b1;
            set_valid   = 1'b1;
            clr_dirty   = 1'b1;
            datamux_sel = D_LLC;
            if (mem_write) begin
              // Revisit CHECK so the write merges into the fresh line.
              refill_set = 1'b1;
              state_d    = CHECK;
            end else begin
              // Read data is forwarded straight from the LLC.
              mem_resp    = 1'b1;
              merdmux_sel = M_LLC;
              load_lru    = 1'b1;
              state_d     = IDLE;
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule
